// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, defaults and tap helper for the SPI frame master
// Contents: spi_state_e FSM encoding, default DIV/WIDTH/DLY_W, tap_select().
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } spi_state_e;

  localparam int DIV_DEF   = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DLY_W_DEF = 4;

  // Widest tap vector the helper accepts; callers zero-extend into it,
  // which caps DLY_W at TAP_IDX_W.
  localparam int TAP_IDX_W = 8;
  localparam int TAP_MAX   = 1 << TAP_IDX_W;

  function automatic logic tap_select(input logic [TAP_MAX-1:0]   taps,
                                      input logic [TAP_IDX_W-1:0] idx);
    return taps[idx];
  endfunction

endpackage

// File: rtl/spi_sample_tap.sv
// rtl/spi_sample_tap.sv - pending-token history with selectable capture tap
// Ports: clk, rst_n (async, active low), clr_i (sync history clear),
//        push_i (token for this cycle), sel_i (tap index, 0 = this cycle),
//        cap_o (capture strobe, combinational).
module spi_sample_tap
  import spi_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [DLY_W-1:0] sel_i,
  output logic             cap_o
);

  localparam int DEPTH = 1 << DLY_W;

  // Tap 0 is the live push, so only DEPTH-1 older tokens need storage.
  logic [DEPTH-2:0] hist_q;
  logic [DEPTH-1:0] taps;

  assign taps  = {hist_q, push_i};
  assign cap_o = tap_select(TAP_MAX'(taps), TAP_IDX_W'(sel_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else if (clr_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= taps[DEPTH-2:0];
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - SPI mode-0 frame initiator with delayed miso capture
// Ports: clk, rst_n (async, active low); host side start, tx_data, sample_dly,
//        ready, done, rx_data; pins cs_n, sclk, mosi, miso.
// Option LOOPBACK_CHECK_EN adds err (sticky) and err_cnt (saturating) outputs
// comparing each received frame against the frame sent.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int DIV   = DIV_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [DLY_W-1:0] sample_dly,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             cs_n,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
`ifdef LOOPBACK_CHECK_EN
  ,
  output logic             err,
  output logic [7:0]       err_cnt
`endif
);

  localparam int HC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BC_W = $clog2(WIDTH + 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(DIV - 1);

  spi_state_e       state_q;
  logic [HC_W-1:0]  hcnt_q;
  logic [BC_W-1:0]  bcnt_q;
  logic [BC_W-1:0]  cap_q;
  logic [WIDTH-1:0] tx_sh_q;
  logic [WIDTH-1:0] rx_sh_q;
  logic [WIDTH-1:0] rx_data_q;
  logic [DLY_W-1:0] dly_q;
  logic             cs_n_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             ready_q;
  logic             done_q;

  logic accept;
  logic push;
  logic cap_stb;

  assign accept = start && ready_q;
  // First cycle of each high phase is the cycle sclk has just risen.
  assign push   = (state_q == SHIFT) && sclk_q && (hcnt_q == HC_MAX);

  spi_sample_tap #(
    .DLY_W (DLY_W)
  ) u_tap (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .push_i (push),
    .sel_i  (dly_q),
    .cap_o  (cap_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      bcnt_q    <= '0;
      cap_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      dly_q     <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Captures run independently of the FSM phase so that late taps
      // can still land while DRAIN waits for them.
      if (cap_stb) begin
        rx_sh_q <= {rx_sh_q[WIDTH-2:0], miso};
        cap_q   <= cap_q + BC_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            tx_sh_q <= tx_data;
            dly_q   <= sample_dly;
            cs_n_q  <= 1'b0;
            mosi_q  <= tx_data[WIDTH-1];
            ready_q <= 1'b0;
            hcnt_q  <= HC_MAX;
            bcnt_q  <= '0;
            cap_q   <= '0;
            rx_sh_q <= '0;
            state_q <= SETUP;
          end
        end

        SETUP: begin
          if (hcnt_q == '0) begin
            sclk_q  <= 1'b1;
            hcnt_q  <= HC_MAX;
            state_q <= SHIFT;
          end else begin
            hcnt_q <= hcnt_q - HC_W'(1);
          end
        end

        SHIFT: begin
          if (hcnt_q != '0) begin
            hcnt_q <= hcnt_q - HC_W'(1);
          end else begin
            hcnt_q <= HC_MAX;
            if (sclk_q) begin
              sclk_q  <= 1'b0;
              mosi_q  <= tx_sh_q[WIDTH-2];
              tx_sh_q <= {tx_sh_q[WIDTH-2:0], 1'b0};
            end else if (bcnt_q == BC_W'(WIDTH - 1)) begin
              state_q <= DRAIN;
            end else begin
              sclk_q <= 1'b1;
              bcnt_q <= bcnt_q + BC_W'(1);
            end
          end
        end

        DRAIN: begin
          if (cap_q == BC_W'(WIDTH)) begin
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            hcnt_q  <= HC_MAX;
            state_q <= HOLD;
            // With a one-cycle HOLD the only HOLD cycle is also the done cycle.
            if (DIV == 1) begin
              done_q    <= 1'b1;
              rx_data_q <= rx_sh_q;
            end
          end
        end

        HOLD: begin
          if (hcnt_q == '0) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            hcnt_q <= hcnt_q - HC_W'(1);
            if (hcnt_q == HC_W'(1)) begin
              done_q    <= 1'b1;
              rx_data_q <= rx_sh_q;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

`ifdef LOOPBACK_CHECK_EN
  logic [WIDTH-1:0] tx_lat_q;
  logic             err_q;
  logic [7:0]       err_cnt_q;

  // Compared the cycle after done, once rx_data holds the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_lat_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (accept) begin
        tx_lat_q <= tx_data;
        err_q    <= 1'b0;
      end else if (done_q && (rx_data_q != tx_lat_q)) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - directed table-driven bench for spi_frame_master
module tb_spi_frame_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] tx_data;
  logic [3:0] sample_dly;
  logic       ready;
  logic       done;
  logic [7:0] rx_data;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
`ifdef LOOPBACK_CHECK_EN
  logic       err;
  logic [7:0] err_cnt;
  int         err_cnt_exp = 0;
`endif

  spi_frame_master #(
    .DIV   (2),
    .WIDTH (8),
    .DLY_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .tx_data    (tx_data),
    .sample_dly (sample_dly),
    .ready      (ready),
    .done       (done),
    .rx_data    (rx_data),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso)
`ifdef LOOPBACK_CHECK_EN
    ,
    .err        (err),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Far-end loop: miso is mosi delayed by loop_dly clk cycles.
  logic [14:0] dline = '0;
  int          loop_dly = 0;
  always @(posedge clk) dline <= {dline[13:0], mosi};
  assign miso = (loop_dly == 0) ? mosi : dline[loop_dly-1];

  // Free-running observation counters, sampled mid-cycle.
  int         rises = 0;
  int         cslow = 0;
  int         done_cnt = 0;
  int         ready_hi = 0;
  logic       sclk_prev = 1'b0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (sclk && !sclk_prev) rises++;
    sclk_prev = sclk;
    if (!cs_n) cslow++;
    if (ready) ready_hi++;
    if (done) begin
      done_cnt++;
      rx_log.push_back(rx_data);
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [3:0] sdly;
    int         ldly;
    logic [7:0] exp_rx;
    int         exp_cslow;
    logic [7:0] mid_tx;
    logic [3:0] mid_sdly;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_ready(input string nm);
    int g = 0;
    while (!ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int r0, c0, d0, g;
    wait_ready(nm);
    loop_dly = v.ldly;
    repeat (2) begin @(posedge clk); #1; end
    r0 = rises; c0 = cslow; d0 = done_cnt;
    start = 1'b1; tx_data = v.tx; sample_dly = v.sdly;
    @(posedge clk); #1;
    start = 1'b0; tx_data = v.mid_tx; sample_dly = v.mid_sdly;
    g = 0;
    while (done_cnt == d0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (done_cnt == d0) chk({nm, "_done_timeout"}, 0, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk({nm, "_rx"}, rx_data, v.exp_rx);
    chk({nm, "_rises"}, rises - r0, 8);
    chk({nm, "_cslow"}, cslow - c0, v.exp_cslow);
    chk({nm, "_done_cnt"}, done_cnt - d0, 1);
`ifdef LOOPBACK_CHECK_EN
    if (v.exp_rx != v.tx) err_cnt_exp++;
    chk({nm, "_err"}, err, (v.exp_rx != v.tx) ? 1 : 0);
    chk({nm, "_err_cnt"}, err_cnt, err_cnt_exp);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, g, q0;

    //           tx     sdly ldly exp_rx cslow mid_tx mid_sdly
    vecs[0] = '{8'hA5, 4'd0,  0,  8'hA5, 35, 8'h5A, 4'd0};
    vecs[1] = '{8'h3C, 4'd3,  3,  8'h3C, 35, 8'h00, 4'd3};
    vecs[2] = '{8'h3C, 4'd0,  3,  8'h1E, 35, 8'h3C, 4'd0};
    vecs[3] = '{8'h81, 4'd15, 15, 8'h81, 47, 8'h7E, 4'd15};
    vecs[4] = '{8'hC3, 4'd0,  0,  8'hC3, 35, 8'h00, 4'd7};
    vecs[5] = '{8'h96, 4'd7,  5,  8'h2C, 39, 8'h96, 4'd7};
    vecs[6] = '{8'hFF, 4'd1,  0,  8'hFF, 35, 8'h00, 4'd1};

    rst_n = 1'b0; start = 1'b0; tx_data = '0; sample_dly = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high across three frames; tx changes after each accept
    wait_ready("held");
    loop_dly = 0;
    d0 = done_cnt; q0 = rx_log.size();
    start = 1'b1; tx_data = 8'h11; sample_dly = 4'd0;
    for (int f = 0; f < 3; f++) begin
      g = 0;
      while (ready && g < 200) begin @(posedge clk); #1; g++; end
      if (ready) chk("held_accept_timeout", 0, 1);
      if (f == 0) ready_hi = 0;
      if (f == 0) tx_data = 8'h22;
      if (f == 1) tx_data = 8'h33;
      if (f == 2) start = 1'b0;
      // ready must stay low for the rest of this frame
      g = 0;
      while (!done && g < 200) begin @(posedge clk); #1; g++; end
      chk($sformatf("held%0d_ready_low", f), ready, 0);
      @(posedge clk); #1;
    end
    chk("held_ready_gaps", ready_hi, 2);
    chk("held_done_cnt", done_cnt - d0, 3);
    chk("held_rx0", (rx_log.size() > q0)     ? rx_log[q0]   : 8'hXX, 8'h11);
    chk("held_rx1", (rx_log.size() > q0 + 1) ? rx_log[q0+1] : 8'hXX, 8'h22);
    chk("held_rx2", (rx_log.size() > q0 + 2) ? rx_log[q0+2] : 8'hXX, 8'h33);

    // reset in the middle of bit 4
    wait_ready("rst");
    d0 = done_cnt; q0 = rises;
    start = 1'b1; tx_data = 8'hF0; sample_dly = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (rises - q0 < 5 && g < 100) begin @(posedge clk); #1; g++; end
    chk("rst_mid_reached_bit4", (rises - q0 >= 5) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", cs_n, 1);
    chk("rst_mid_sclk", sclk, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rx", rx_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef LOOPBACK_CHECK_EN
    err_cnt_exp = 0;
`endif
    repeat (20) begin @(posedge clk); #1; end
    chk("rst_mid_no_done", done_cnt - d0, 0);
    run_frame('{8'h5A, 4'd0, 0, 8'h5A, 35, 8'h00, 4'd0}, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
